// File: rtl/lcd_nibble_writer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_nibble_writer
//  Purpose  : Writes bytes to a character LCD over its 4-bit bus, high nibble
//             first, with timed E strobes and a fixed post-write busy wait
//             (busy flag is never read; RW is tied low).
//  Option   : LCD_NIBBLE_INIT_EN - built-in power-on init sequence after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_nibble_writer #(
`ifdef LCD_NIBBLE_INIT_EN
    parameter int POWERON_CYC    = 1500000,   // power-up settle time
    parameter int INIT_FIRST_CYC = 410000,    // wait after first 0x3 nibble
`endif
    parameter int SETUP_CYC      = 4,
    parameter int E_HIGH_CYC     = 24,
    parameter int HOLD_CYC       = 2,
    parameter int GAP_CYC        = 100,
    parameter int CHAR_WAIT_CYC  = 4000,
    parameter int CLEAR_WAIT_CYC = 164000
) (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active low
    input  logic [7:0] din,
    input  logic       rs_in,
    input  logic       valid,
    output logic       ready,
    output logic [3:0] LCD_DATA,
    output logic       RS,
    output logic       RW,
    output logic       E
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_MAX_BASE = f_max(f_max(f_max(SETUP_CYC, E_HIGH_CYC),
                                            f_max(HOLD_CYC, GAP_CYC)),
                                      f_max(CHAR_WAIT_CYC, CLEAR_WAIT_CYC));
`ifdef LCD_NIBBLE_INIT_EN
    localparam int c_MAX_CYC  = f_max(c_MAX_BASE, f_max(POWERON_CYC, INIT_FIRST_CYC));
`else
    localparam int c_MAX_CYC  = c_MAX_BASE;
`endif
    localparam int c_CNT_W    = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // State encoding
    localparam logic [3:0] c_S_IDLE     = 4'd0;
    localparam logic [3:0] c_S_SETUP_HI = 4'd1;
    localparam logic [3:0] c_S_EHI_HI   = 4'd2;
    localparam logic [3:0] c_S_HOLD_HI  = 4'd3;
    localparam logic [3:0] c_S_GAP      = 4'd4;
    localparam logic [3:0] c_S_SETUP_LO = 4'd5;
    localparam logic [3:0] c_S_EHI_LO   = 4'd6;
    localparam logic [3:0] c_S_HOLD_LO  = 4'd7;
    localparam logic [3:0] c_S_WAIT     = 4'd8;
    localparam logic [3:0] c_S_PWR      = 4'd9;

    // A state lasting N cycles is entered with the counter at N-1 and left
    // on the cycle the counter reads zero, so it never wraps.
    function automatic logic [c_CNT_W-1:0] f_load(input int cyc);
        return c_CNT_W'(cyc - 1);
    endfunction

    logic [3:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_byte;
    logic               r_rs;
    logic [3:0]         r_data;
    logic               r_e;
    logic               r_ready;

    logic [3:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         w_byte_nxt;
    logic               w_rs_nxt;
    logic [3:0]         w_data_nxt;
    logic               w_e_nxt;
    logic               w_ready_nxt;
    logic               w_cnt_done;
    logic               w_accept;
    logic               w_clear_cmd;
    logic [c_CNT_W-1:0] w_wait_load;

`ifdef LCD_NIBBLE_INIT_EN
    logic               r_init_active;
    logic [2:0]         r_init_step;
    logic               r_single;
    logic               w_init_active_nxt;
    logic [2:0]         w_init_step_nxt;
    logic               w_single_nxt;
    logic               w_launch;
`endif

    assign w_cnt_done  = (r_cnt == '0);
    assign w_accept    = valid & r_ready;
    // Clear (0x01) and return-home (0x02/0x03) are the slow commands
    assign w_clear_cmd = !r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));

    // Choose the post-write busy time for the byte or nibble just written
    always_comb begin
        w_wait_load = w_clear_cmd ? f_load(CLEAR_WAIT_CYC) : f_load(CHAR_WAIT_CYC);
`ifdef LCD_NIBBLE_INIT_EN
        if (r_single) begin
            w_wait_load = (r_init_step == 3'd0) ? f_load(INIT_FIRST_CYC) : f_load(CHAR_WAIT_CYC);
        end
`endif
    end

    // Next-state, counter reload and registered-output next values
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_done ? r_cnt : (r_cnt - c_CNT_ONE);
        w_byte_nxt  = r_byte;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
`ifdef LCD_NIBBLE_INIT_EN
        w_init_active_nxt = r_init_active;
        w_init_step_nxt   = r_init_step;
        w_single_nxt      = r_single;
        w_launch          = 1'b0;
`endif
        case (r_state)
            c_S_IDLE: begin
`ifdef LCD_NIBBLE_INIT_EN
                if (r_init_active) begin
                    w_state_nxt = c_S_PWR;
                    w_cnt_nxt   = f_load(POWERON_CYC);
                end else
`endif
                if (w_accept) begin
                    w_byte_nxt  = din;
                    w_rs_nxt    = rs_in;
                    w_data_nxt  = din[7:4];
                    w_state_nxt = c_S_SETUP_HI;
                    w_cnt_nxt   = f_load(SETUP_CYC);
                end
            end
            c_S_SETUP_HI: if (w_cnt_done) begin
                w_state_nxt = c_S_EHI_HI;
                w_cnt_nxt   = f_load(E_HIGH_CYC);
            end
            c_S_EHI_HI: if (w_cnt_done) begin
                w_state_nxt = c_S_HOLD_HI;
                w_cnt_nxt   = f_load(HOLD_CYC);
            end
            c_S_HOLD_HI: if (w_cnt_done) begin
                w_state_nxt = c_S_GAP;
                w_cnt_nxt   = f_load(GAP_CYC);
            end
            c_S_GAP: if (w_cnt_done) begin
                // Low nibble only appears once the gap is over
                w_state_nxt = c_S_SETUP_LO;
                w_cnt_nxt   = f_load(SETUP_CYC);
                w_data_nxt  = r_byte[3:0];
            end
            c_S_SETUP_LO: if (w_cnt_done) begin
                w_state_nxt = c_S_EHI_LO;
                w_cnt_nxt   = f_load(E_HIGH_CYC);
            end
            c_S_EHI_LO: if (w_cnt_done) begin
                w_state_nxt = c_S_HOLD_LO;
                w_cnt_nxt   = f_load(HOLD_CYC);
            end
            c_S_HOLD_LO: if (w_cnt_done) begin
                w_state_nxt = c_S_WAIT;
                w_cnt_nxt   = w_wait_load;
            end
            c_S_WAIT: if (w_cnt_done) begin
`ifdef LCD_NIBBLE_INIT_EN
                if (r_init_active && (r_init_step != 3'd7)) begin
                    w_launch = 1'b1;
                end else begin
                    w_state_nxt       = c_S_IDLE;
                    w_init_active_nxt = 1'b0;
                end
`else
                w_state_nxt = c_S_IDLE;
`endif
            end
`ifdef LCD_NIBBLE_INIT_EN
            c_S_PWR: if (w_cnt_done) begin
                w_launch = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

`ifdef LCD_NIBBLE_INIT_EN
        // Start the next init write: steps 0-3 are single 0x3/0x3/0x3/0x2
        // nibbles, steps 4-7 are the full bytes 0x28, 0x06, 0x0C, 0x01.
        if (w_launch) begin
            w_init_step_nxt = (r_state == c_S_PWR) ? 3'd0 : (r_init_step + 3'd1);
            w_rs_nxt        = 1'b0;
            case (w_init_step_nxt)
                3'd0, 3'd1, 3'd2: w_byte_nxt = 8'h03;
                3'd3:             w_byte_nxt = 8'h02;
                3'd4:             w_byte_nxt = 8'h28;
                3'd5:             w_byte_nxt = 8'h06;
                3'd6:             w_byte_nxt = 8'h0C;
                default:          w_byte_nxt = 8'h01;
            endcase
            w_single_nxt = ~w_init_step_nxt[2];
            w_cnt_nxt    = f_load(SETUP_CYC);
            if (w_single_nxt) begin
                w_data_nxt  = w_byte_nxt[3:0];
                w_state_nxt = c_S_SETUP_LO;
            end else begin
                w_data_nxt  = w_byte_nxt[7:4];
                w_state_nxt = c_S_SETUP_HI;
            end
        end
`endif

        w_e_nxt     = (w_state_nxt == c_S_EHI_HI) || (w_state_nxt == c_S_EHI_LO);
        w_ready_nxt = (r_state == c_S_IDLE) && !w_accept;
`ifdef LCD_NIBBLE_INIT_EN
        w_ready_nxt = w_ready_nxt && !r_init_active;
`endif
    end

    // State, counter and output registers; reset drops E at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_byte  <= 8'h00;
            r_rs    <= 1'b0;
            r_data  <= 4'h0;
            r_e     <= 1'b0;
            r_ready <= 1'b0;
`ifdef LCD_NIBBLE_INIT_EN
            r_init_active <= 1'b1;
            r_init_step   <= 3'd0;
            r_single      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_byte  <= w_byte_nxt;
            r_rs    <= w_rs_nxt;
            r_data  <= w_data_nxt;
            r_e     <= w_e_nxt;
            r_ready <= w_ready_nxt;
`ifdef LCD_NIBBLE_INIT_EN
            r_init_active <= w_init_active_nxt;
            r_init_step   <= w_init_step_nxt;
            r_single      <= w_single_nxt;
`endif
        end
    end

    assign ready    = r_ready;
    assign LCD_DATA = r_data;
    assign RS       = r_rs;
    assign RW       = 1'b0;
    assign E        = r_e;

endmodule
`default_nettype wire

// File: tb/tb_lcd_nibble_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_nibble_writer
//  Purpose  : Directed self-checking bench for lcd_nibble_writer using scaled
//             timing (setup 2, E high 3, hold 1, gap 4, waits 10/50).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_nibble_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       rs_in;
    logic       valid;
    logic       ready;
    logic [3:0] LCD_DATA;
    logic       RS;
    logic       RW;
    logic       E;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse log built by the monitor
    logic [3:0] q_nib[$];
    logic       q_rs[$];
    int         q_len[$];
    int         hi_len = 0;
    logic       e_prev = 1'b0;
    logic [3:0] last_data = 4'h0;
    int         rw_bad = 0;
    int         unstable = 0;

    lcd_nibble_writer #(
        .SETUP_CYC      (2),
        .E_HIGH_CYC     (3),
        .HOLD_CYC       (1),
        .GAP_CYC        (4),
        .CHAR_WAIT_CYC  (10),
        .CLEAR_WAIT_CYC (50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .rs_in    (rs_in),
        .valid    (valid),
        .ready    (ready),
        .LCD_DATA (LCD_DATA),
        .RS       (RS),
        .RW       (RW),
        .E        (E)
    );

    always #5 clk = ~clk;

    // Record every E pulse (nibble, RS, width) sampled on the falling edge
    always @(negedge clk) begin
        if (RW !== 1'b0) rw_bad++;
        if (E === 1'b1 && !e_prev) begin
            q_nib.push_back(LCD_DATA);
            q_rs.push_back(RS);
            hi_len    = 1;
            last_data = LCD_DATA;
        end else if (E === 1'b1 && e_prev) begin
            hi_len++;
            if (LCD_DATA !== last_data) unstable++;
        end else if (E !== 1'b1 && e_prev) begin
            q_len.push_back(hi_len);
        end
        e_prev = (E === 1'b1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_nib.delete();
        q_rs.delete();
        q_len.delete();
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", ready, 1);
    endtask

    // Count edges from just after an accepting edge until ready is seen high
    task automatic measure_latency(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, n, exp_lat);
    endtask

    task automatic send(input logic [7:0] b, input logic rs, input int exp_lat);
        wait_ready();
        clear_log();
        din   = b;
        rs_in = rs;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check_eq("busy_after_accept", ready, 0);
        measure_latency("latency", exp_lat);
    endtask

    task automatic expect_pulse(input int idx, input logic [3:0] nib, input logic rs);
        if (q_nib.size() > idx) begin
            check_eq("pulse_nibble", q_nib[idx], nib);
            check_eq("pulse_rs", q_rs[idx], rs);
        end
        if (q_len.size() > idx) begin
            check_eq("pulse_width", q_len[idx], 3);
        end
    endtask

    task automatic expect_byte(input logic [3:0] hi, input logic [3:0] lo, input logic rs);
        check_eq("pulse_count", q_nib.size(), 2);
        check_eq("pulse_ends", q_len.size(), 2);
        expect_pulse(0, hi, rs);
        expect_pulse(1, lo, rs);
    endtask

    initial begin
        int n;
        int hi;
        reset = 1'b0;
        din   = 8'h00;
        rs_in = 1'b0;
        valid = 1'b0;

        // 1. Reset: outputs low throughout, ready one edge after release
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3 || i == 8) begin
                check_eq("rst_ready", ready, 0);
                check_eq("rst_e", E, 0);
                check_eq("rst_data", LCD_DATA, 0);
                check_eq("rst_rs", RS, 0);
                check_eq("rst_rw", RW, 0);
            end
        end
        reset = 1'b1;
        #1;
        check_eq("ready_before_edge", ready, 0);
        @(posedge clk);
        #1;
        check_eq("ready_first_edge", ready, 1);

        // 2. Data write 0x41
        send(8'h41, 1'b1, 27);
        expect_byte(4'h4, 4'h1, 1'b1);
        check_eq("idle_data_kept", LCD_DATA, 4'h1);
        check_eq("idle_rs_kept", RS, 1);

        // 3. Clear command, then same byte as data
        send(8'h01, 1'b0, 67);
        expect_byte(4'h0, 4'h1, 1'b0);
        send(8'h01, 1'b1, 27);
        expect_byte(4'h0, 4'h1, 1'b1);
        send(8'h03, 1'b0, 67);
        expect_byte(4'h0, 4'h3, 1'b0);

        // 4. Handshake: valid held high across two transactions
        wait_ready();
        clear_log();
        din   = 8'h48;
        rs_in = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hs_accept1", ready, 0);
        din = 8'h49;
        measure_latency("hs_latency1", 27);
        hi = 0;
        while (ready && hi < 10) begin
            hi++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        check_eq("hs_ready_cycles", hi, 1);
        measure_latency("hs_latency2", 27);
        repeat (5) @(posedge clk);
        #1;
        check_eq("hs_pulse_count", q_nib.size(), 4);
        check_eq("hs_idle_ready", ready, 1);
        expect_pulse(0, 4'h4, 1'b1);
        expect_pulse(1, 4'h8, 1'b1);
        expect_pulse(2, 4'h4, 1'b1);
        expect_pulse(3, 4'h9, 1'b1);

        // 5. Reset in the middle of an E pulse
        wait_ready();
        din   = 8'h55;
        rs_in = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        n = 0;
        while (E !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("mide_e_high", E, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mide_e_drop", E, 0);
        check_eq("mide_ready", ready, 0);
        check_eq("mide_data", LCD_DATA, 0);
        check_eq("mide_rs", RS, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_log();
        @(posedge clk);
        #1;
        check_eq("mide_ready_after", ready, 1);
        repeat (40) @(posedge clk);
        #1;
        check_eq("mide_no_pulse", q_nib.size(), 0);
        check_eq("mide_e_idle", E, 0);

        check_eq("rw_always_low", rw_bad, 0);
        check_eq("data_stable_e_high", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Downstream LCD stage: takes byte-wide command/character writes from the LCD test controller over a valid/ready handshake.
- Drives the character LCD's 4-bit bus (LCD_DATA, RS, RW, E): high nibble first, then low nibble.
- Enforces E pulse timing and the post-command busy time without reading the busy flag; RW is tied to write.
- Timing defaults assume the 100 MHz board clock (10 ns period).

Parameters:
SETUP_CYC, 4, cycles RS/LCD_DATA are stable with E=0 before E rises (min 1)
E_HIGH_CYC, 24, cycles E is held high (min 1)
HOLD_CYC, 2, cycles RS/LCD_DATA are held after E falls (min 1)
GAP_CYC, 100, E-low idle cycles between high and low nibble (min 1)
CHAR_WAIT_CYC, 4000, wait after a normal write (40 us)
CLEAR_WAIT_CYC, 164000, wait after clear/home commands (1.64 ms)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
din  in  8  byte to write
rs_in  in  1  0 = command, 1 = data
valid  in  1  request; qualified with ready
ready  out  1  block idle and able to accept
LCD_DATA  out  4  LCD data nibble
RS  out  1  LCD register select
RW  out  1  LCD read/write, constant 0
E  out  1  LCD enable strobe

Behaviour:
- Reset (reset=0, asynchronous): E=0, LCD_DATA=0, RS=0, RW=0, ready=0, FSM=IDLE, counter=0. E must fall immediately, even mid-pulse.
- First rising edge after reset release: ready goes 1 (init disabled).
- All outputs are registered; RW is 0 at all times.
- Accept: rising edge with valid=1 and ready=1.
  - At that edge: latch din/rs_in, ready goes 0, FSM enters SETUP_HI, LCD_DATA=din[7:4], RS=rs_in.
  - valid while ready=0 is ignored; there is no buffering.
- States and durations; the counter reloads on each transition:
  - IDLE: ready=1.
  - SETUP_HI: E=0 for SETUP_CYC cycles.
  - EHI_HI: E=1 for E_HIGH_CYC cycles.
  - HOLD_HI: E=0 for HOLD_CYC cycles.
  - GAP: E=0 for GAP_CYC cycles. LCD_DATA switches to latched din[3:0] on entry to SETUP_LO, not before.
  - SETUP_LO, EHI_LO, HOLD_LO: same as the high-nibble states.
  - WAIT: E=0. Lasts CLEAR_WAIT_CYC if rs=0 and latched byte is 0x01, 0x02 or 0x03; otherwise CHAR_WAIT_CYC.
  - IDLE again: ready=1.
- Latency: ready reasserts exactly 2*(SETUP_CYC+E_HIGH_CYC+HOLD_CYC)+GAP_CYC+WAIT+1 edges after the accepting edge.
- Back-to-back: valid held high is accepted on the first edge ready=1 is seen; at least one idle cycle between transactions.
- LCD_DATA and RS keep their last values in IDLE.
- Counter width is $clog2 of the largest parameter + 1; the counter never wraps.

Optional Feature:
- Macro LCD_NIBBLE_INIT_EN.
- Defined:
  - After reset release, ready stays 0 while a built-in power-on sequence runs:
    - Wait 1,500,000 cycles (15 ms).
    - Single-nibble writes (RS=0, one E pulse, then CHAR_WAIT_CYC wait) of 0x3, 0x3, 0x3, 0x2. The first wait is extended to 410,000 cycles.
    - Full byte commands 0x28, 0x06, 0x0C, 0x01 using normal timing; 0x01 gets CLEAR_WAIT_CYC.
  - ready first rises after the final wait.
  - A reset mid-sequence restarts the sequence from the beginning.
- Undefined: no init logic; ready=1 on the first edge after reset release.

Test Plan:
(Param override for sim: SETUP_CYC=2, E_HIGH_CYC=3, HOLD_CYC=1, GAP_CYC=4, CHAR_WAIT_CYC=10, CLEAR_WAIT_CYC=50.)
1. Reset: hold reset=0 for 10 cycles, release -> outputs all 0 during reset; ready=1 one edge after release; RW=0 throughout.
2. Data write: din=0x41, rs_in=1, valid pulsed for 1 cycle -> LCD_DATA=0x4 for E pulse 1 (E high exactly 3 cycles), LCD_DATA=0x1 for E pulse 2; RS=1 throughout; ready returns 27 edges after accept.
3. Clear: din=0x01, rs_in=0 -> nibbles 0x0 then 0x1, RS=0; ready returns 67 edges after accept. Same byte with rs_in=1 -> 27 edges.
4. Handshake: valid held high with 0x48 then 0x49 -> exactly two transactions in order; extra valid during busy is not accepted; one ready=1 cycle between them.
5. Reset mid-E: assert reset while E=1 -> E=0 within the same cycle (no clock edge); after release, ready=1 and no residual pulse.
6. With LCD_NIBBLE_INIT_EN (scaled init waits) -> observe 4 single E pulses with nibbles 3,3,3,2, then byte pairs 2/8, 0/6, 0/C, 0/1; ready rises only after the last wait.
